onehot_ring: RTL and testbench

- Registered, parametrised one-hot position register with binary-index load, rotate up/down with wrap-around, clear, and index read-back.
- Successor to the team's fixed 3-to-8 combinational decoder.
- Drives N one-hot select lines (channel/LED/mux selects) from a command interface with a valid/ready handshake and an update strobe.
- With the optional feature, it steps autonomously at a programmable dwell rate.

---
 rtl/onehot_ring.sv | 131 +++++++++++++
 tb/tb_onehot_ring.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/onehot_ring.sv
// onehot_ring: registered one-hot position register with load/rotate/clear commands.
// Define ONEHOT_RING_AUTO_EN to enable autonomous up-stepping at a programmable dwell rate.
module onehot_ring #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = $clog2(N),
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_cmd,
  input  logic [IW-1:0] in_idx,
  output logic [N-1:0]  out,
  output logic [IW-1:0] out_idx,
  output logic          out_active,
  output logic          upd,
  output logic          err,
  input  logic [DW-1:0] dwell,
  input  logic          auto_go
);

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_UP    = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          accept;
  logic          auto_step;
  logic [IW-1:0] up_idx;
  logic [IW-1:0] down_idx;
  logic [IW-1:0] nxt_idx;
  logic          nxt_active;
  logic          nxt_upd;
  logic          nxt_err;

  assign accept = in_valid & in_ready;

  // Wrap at N-1 rather than 2^IW-1 so non-power-of-two N never overflows.
  assign up_idx   = !out_active ? '0
                  : (out_idx == LAST_IDX) ? '0 : out_idx + IW'(1);
  assign down_idx = !out_active ? LAST_IDX
                  : (out_idx == '0) ? LAST_IDX : out_idx - IW'(1);

`ifdef ONEHOT_RING_AUTO_EN
  logic [DW-1:0] dwell_cnt;
  logic          cnt_run;

  assign in_ready  = ~auto_go;
  assign cnt_run   = auto_go & out_active;
  assign auto_step = cnt_run & (dwell_cnt == dwell);

  // Dwell counter: runs 0..dwell while auto-stepping, held at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (!cnt_run || auto_step) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end
`else
  logic unused_auto;

  assign unused_auto = ^{dwell, auto_go};
  assign in_ready    = 1'b1;
  assign auto_step   = 1'b0;
`endif

  // Next position from the accepted command or an auto step.
  always_comb begin
    nxt_idx    = out_idx;
    nxt_active = out_active;
    nxt_upd    = 1'b0;
    nxt_err    = 1'b0;
    if (auto_step) begin
      nxt_idx = up_idx;
      nxt_upd = 1'b1;
    end else if (accept) begin
      nxt_upd = 1'b1;
      case (cmd_e'(in_cmd))
        CMD_LOAD: begin
          if (32'(in_idx) < N) begin
            nxt_idx    = in_idx;
            nxt_active = 1'b1;
          end else begin
            nxt_err = 1'b1;
          end
        end
        CMD_UP: begin
          nxt_idx    = up_idx;
          nxt_active = 1'b1;
        end
        CMD_DOWN: begin
          nxt_idx    = down_idx;
          nxt_active = 1'b1;
        end
        CMD_CLEAR: begin
          nxt_idx    = '0;
          nxt_active = 1'b0;
        end
        default: begin
          nxt_idx = out_idx;
        end
      endcase
    end
  end

  // One-hot vector is decoded from the index so the two can never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= N'(1);
      out_idx    <= '0;
      out_active <= 1'b1;
      upd        <= 1'b0;
      err        <= 1'b0;
    end else begin
      out        <= nxt_active ? (N'(1) << nxt_idx) : '0;
      out_idx    <= nxt_idx;
      out_active <= nxt_active;
      upd        <= nxt_upd;
      err        <= nxt_err;
    end
  end

endmodule

// File: tb/tb_onehot_ring.sv
// tb_onehot_ring: drives an N=8 and an N=6 instance with identical commands and
// compares both against a position-based reference model.
module tb_onehot_ring;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_cmd = 2'b00;
  logic [2:0] in_idx = 3'd0;
  logic [7:0] dwell = 8'd0;
  logic       auto_go = 1'b0;

  logic       rdy8, rdy6;
  logic [7:0] out8;
  logic [5:0] out6;
  logic [2:0] idx8, idx6;
  logic       act8, act6, upd8, upd6, err8, err6;

  int checks = 0;
  int errors = 0;

  // Reference state: position of the set bit, -1 when cleared.
  int pos[2];
  int nn[2] = '{8, 6};
  bit exp_upd[2];
  bit exp_err[2];

  always #5 clk = ~clk;

  onehot_ring #(.N(8), .DW(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .in_cmd(in_cmd), .in_idx(in_idx), .out(out8), .out_idx(idx8),
    .out_active(act8), .upd(upd8), .err(err8), .dwell(dwell), .auto_go(auto_go)
  );

  onehot_ring #(.N(6), .DW(8)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy6),
    .in_cmd(in_cmd), .in_idx(in_idx), .out(out6), .out_idx(idx6),
    .out_active(act6), .upd(upd6), .err(err6), .dwell(dwell), .auto_go(auto_go)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_out(input int d);
    return (pos[d] < 0) ? 32'd0 : (32'd1 << pos[d]);
  endfunction

  function automatic logic [31:0] exp_idx(input int d);
    return (pos[d] < 0) ? 32'd0 : 32'(pos[d]);
  endfunction

  function automatic logic [31:0] exp_act(input int d);
    return (pos[d] >= 0) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_all(input string step);
    chk({step, " n8.out"},    32'(out8), exp_out(0));
    chk({step, " n8.idx"},    32'(idx8), exp_idx(0));
    chk({step, " n8.active"}, 32'(act8), exp_act(0));
    chk({step, " n8.upd"},    32'(upd8), 32'(exp_upd[0]));
    chk({step, " n8.err"},    32'(err8), 32'(exp_err[0]));
    chk({step, " n8.ready"},  32'(rdy8), 32'(!auto_go));
    chk({step, " n6.out"},    32'(out6), exp_out(1));
    chk({step, " n6.idx"},    32'(idx6), exp_idx(1));
    chk({step, " n6.active"}, 32'(act6), exp_act(1));
    chk({step, " n6.upd"},    32'(upd6), 32'(exp_upd[1]));
    chk({step, " n6.err"},    32'(err6), 32'(exp_err[1]));
    chk({step, " n6.ready"},  32'(rdy6), 32'(!auto_go));
  endtask

  task automatic model_apply(input logic r, input logic v, input logic [1:0] c, input logic [2:0] i);
    for (int d = 0; d < 2; d++) begin
      exp_upd[d] = 1'b0;
      exp_err[d] = 1'b0;
      if (r) begin
        pos[d] = 0;
      end else if (v && !auto_go) begin
        exp_upd[d] = 1'b1;
        case (c)
          2'd0: if (int'(i) < nn[d]) pos[d] = int'(i); else exp_err[d] = 1'b1;
          2'd1: pos[d] = (pos[d] < 0) ? 0 : (pos[d] + 1) % nn[d];
          2'd2: pos[d] = (pos[d] < 0) ? nn[d] - 1 : (pos[d] + nn[d] - 1) % nn[d];
          default: pos[d] = -1;
        endcase
      end
    end
  endtask

  task automatic cycle(input string step, input logic r, input logic v,
                       input logic [1:0] c, input logic [2:0] i);
    rst      = r;
    in_valid = v;
    in_cmd   = c;
    in_idx   = i;
    @(posedge clk);
    #1;
    model_apply(r, v, c, i);
    check_all(step);
  endtask

  initial begin
    pos[0] = 0;
    pos[1] = 0;

    cycle("reset", 1'b1, 1'b0, 2'd0, 3'd0);
    for (int k = 0; k < 3; k++) cycle("idle", 1'b0, 1'b0, 2'd0, 3'd0);

    cycle("load5", 1'b0, 1'b1, 2'd0, 3'd5);
    for (int k = 0; k < 3; k++) cycle("up", 1'b0, 1'b1, 2'd1, 3'd0);

    cycle("clear",       1'b0, 1'b1, 2'd3, 3'd0);
    cycle("clear_again", 1'b0, 1'b1, 2'd3, 3'd0);
    cycle("down_clr",    1'b0, 1'b1, 2'd2, 3'd0);
    cycle("clear2",      1'b0, 1'b1, 2'd3, 3'd0);
    cycle("up_clr",      1'b0, 1'b1, 2'd1, 3'd0);

    cycle("load2",      1'b0, 1'b1, 2'd0, 3'd2);
    cycle("load6",      1'b0, 1'b1, 2'd0, 3'd6);
    cycle("after_load6", 1'b0, 1'b0, 2'd0, 3'd0);
    cycle("load7",      1'b0, 1'b1, 2'd0, 3'd7);

    cycle("b2b_load2", 1'b0, 1'b1, 2'd0, 3'd2);
    for (int k = 0; k < 3; k++) cycle("b2b_down", 1'b0, 1'b1, 2'd2, 3'd0);

    cycle("load4",  1'b0, 1'b1, 2'd0, 3'd4);
    cycle("rst_up", 1'b1, 1'b1, 2'd1, 3'd0);

`ifdef ONEHOT_RING_AUTO_EN
    cycle("auto_load0", 1'b0, 1'b1, 2'd0, 3'd0);
    dwell    = 8'd2;
    auto_go  = 1'b1;
    in_valid = 1'b1;
    in_cmd   = 2'd3;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        exp_err[d] = 1'b0;
        exp_upd[d] = (k % 3 == 0);
        if (k % 3 == 0) pos[d] = (pos[d] + 1) % nn[d];
      end
      check_all("auto");
    end
    auto_go  = 1'b0;
    in_valid = 1'b0;
    dwell    = 8'd0;
`endif

    for (int k = 0; k < 400; k++) begin
      cycle("rand",
            ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
